// File: rtl/sha256_round_engine.sv
// SHA-256 compression responder: 16-word message buffer, 8-word chaining hash,
// one round per clock with an in-place rolling message schedule.
module sha256_round_engine #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [3:0]        ld_idx,
    input  logic [WORD_W-1:0] ld_word,
    input  logic              init_hash,
    input  logic              start_sha,
    input  logic [2:0]        res_sel,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] digest_word
);

    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    state_t      state, state_nxt;
    logic [31:0] msg [16];
    logic [31:0] hv  [8];
    logic [31:0] wv  [8];
    logic [5:0]  t;
    logic [3:0]  ti;
    logic [31:0] w_sched, wt, t1, t2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sha) state_nxt = RUN;
            RUN:     if (t == LAST_T) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer slot t&15 holds W[t-16] on entry and receives W[t] on exit.
    always_comb begin
        ti      = t[3:0];
        w_sched = ssig1(msg[ti - 4'd2]) + msg[ti - 4'd7] + ssig0(msg[ti - 4'd15]) + msg[ti];
        wt      = (t[5:4] == 2'b00) ? msg[ti] : w_sched;
        t1      = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[t] + wt;
        t2      = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) msg[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= IV[i];
                wv[i] <= '0;
            end
            t    <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FINAL);
            case (state)
                IDLE: begin
                    if (ld_valid) msg[ld_idx] <= ld_word;
                    if (init_hash)
                        for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                    if (start_sha) begin
                        t <= '0;
                        for (int i = 0; i < 8; i++) wv[i] <= init_hash ? IV[i] : hv[i];
                    end
                end
                RUN: begin
                    msg[ti] <= wt;
                    wv[0]   <= t1 + t2;
                    wv[1]   <= wv[0];
                    wv[2]   <= wv[1];
                    wv[3]   <= wv[2];
                    wv[4]   <= wv[3] + t1;
                    wv[5]   <= wv[4];
                    wv[6]   <= wv[5];
                    wv[7]   <= wv[6];
                    t       <= t + 6'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign digest_word = hv[res_sel];

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine: directed vectors plus random blocks
// checked against a straightforward SHA-256 compression model.
module tb_sha256_round_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [3:0]  ld_idx;
    logic [31:0] ld_word;
    logic        init_hash;
    logic        start_sha;
    logic [2:0]  res_sel, stim_sel, mon_sel;
    logic        mon_active;
    logic        busy, done;
    logic [31:0] digest_word;

    sha256_round_engine #(.ROUNDS(64), .WORD_W(32)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_idx(ld_idx),
        .ld_word(ld_word), .init_hash(init_hash), .start_sha(start_sha),
        .res_sel(res_sel), .busy(busy), .done(done), .digest_word(digest_word));

    assign res_sel = mon_active ? mon_sel : stim_sel;

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] exp_h [$];
    int unsigned  exp_cyc [$];
    logic [255:0] model_h;

    localparam logic [255:0] IV_H  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_H = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMP_H = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_H = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] hword(input logic [255:0] h, input int i);
        return h[255-32*i -: 32];
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry schedule, then the 64 rounds, then the fold.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s1, s0, t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = m[i];
            else begin
                s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
                s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
                w[i] = s1 + w[i-7] + s0 + w[i-16];
            end
        end
        for (int i = 0; i < 8; i++) v[i] = hword(hin, i);
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hword(hin, i) + v[i];
        return hout;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %08h required %08h", name, act, req);
        end
    endtask

    // Monitor: on every done pulse pop the expected hash and read all eight words.
    initial begin
        logic [255:0] eh;
        int unsigned  ec;
        mon_active = 1'b0;
        mon_sel    = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_h.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual 1 required 0");
                end else begin
                    eh = exp_h.pop_front();
                    ec = exp_cyc.pop_front();
                    chk("done_latency", cyc, ec);
                    mon_active = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        mon_sel = 3'(i);
                        #1;
                        chk($sformatf("digest_h%0d", i), digest_word, hword(eh, i));
                    end
                    mon_active = 1'b0;
                end
                done_cnt++;
            end
        end
    end

    // mode: 0 = run will be aborted, 1 = expect model result, 2 = expect given constant
    task automatic run_block(input logic [31:0] b [16], input bit do_init, input bit merge,
                             input int mode, input logic [255:0] cval);
        logic [255:0] pre_h, res;
        int unsigned  s;
        logic [2:0]   sel;
        for (int i = 0; i < (merge ? 15 : 16); i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_idx = 4'(i); ld_word = b[i];
        end
        @(negedge clk);
        ld_valid = merge; ld_idx = 4'd15; ld_word = b[15];
        init_hash = do_init; start_sha = 1'b1;
        @(posedge clk);
        #1;
        ld_valid = 1'b0; init_hash = 1'b0; start_sha = 1'b0;
        s = cyc;
        pre_h = do_init ? IV_H : model_h;
        res   = compress(pre_h, b);
        if (mode != 0) begin
            model_h = (mode == 2) ? cval : res;
            exp_h.push_back(model_h);
            exp_cyc.push_back(s + 65);
        end
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            sel = 3'($urandom_range(0, 7));
            stim_sel = sel;
            #1;
            chk("digest_during_run", digest_word, hword(pre_h, int'(sel)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #9;
            if (done_cnt != d0) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] abc_blk [16];
    logic [31:0] emp_blk [16];
    logic [31:0] two1_blk [16];
    logic [31:0] two2_blk [16];
    logic [31:0] rnd_blk [16];

    initial begin
        int d0;
        abc_blk  = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        emp_blk  = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        two1_blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2_blk = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};

        reset = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_word = '0;
        init_hash = 1'b0; start_sha = 1'b0; stim_sel = '0;
        model_h = IV_H;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            stim_sel = 3'(i);
            #1;
            chk($sformatf("reset_iv_h%0d", i), digest_word, hword(IV_H, i));
        end
        reset = 1'b0;

        // "abc" with the last word landing in the start cycle
        run_block(abc_blk, 1'b0, 1'b1, 2, ABC_H);
        wait_done();
        // init_hash and start_sha together: IV wins over the previous digest
        run_block(abc_blk, 1'b1, 1'b0, 2, ABC_H);
        wait_done();
        run_block(emp_blk, 1'b1, 1'b0, 2, EMP_H);
        wait_done();
        run_block(two1_blk, 1'b1, 1'b0, 1, '0);
        wait_done();
        run_block(two2_blk, 1'b0, 1'b0, 2, TWO_H);
        wait_done();

        // Inputs poked at t=10 must be ignored
        d0 = done_cnt;
        run_block(abc_blk, 1'b1, 1'b0, 2, ABC_H);
        repeat (7) @(posedge clk);
        #1;
        start_sha = 1'b1; init_hash = 1'b1; ld_valid = 1'b1; ld_idx = 4'd0; ld_word = 32'hffffffff;
        @(posedge clk);
        #1;
        start_sha = 1'b0; init_hash = 1'b0; ld_valid = 1'b0;
        wait_done();
        repeat (70) @(negedge clk);
        chk("single_done_pulse", 32'(done_cnt - d0), 32'd1);

        // Reset at t=30 of a run
        d0 = done_cnt;
        run_block(abc_blk, 1'b1, 1'b0, 0, '0);
        repeat (27) @(posedge clk);
        #1;
        reset = 1'b1;
        stim_sel = 3'd0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_h0", digest_word, 32'h6a09e667);
        @(negedge clk);
        reset = 1'b0;
        model_h = IV_H;
        repeat (80) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_block(abc_blk, 1'b0, 1'b0, 2, ABC_H);
        wait_done();

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
            run_block(rnd_blk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, '0);
            wait_done();
        end

        repeat (2) @(negedge clk);
        if (exp_h.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations actual %0d required 0", exp_h.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
